// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, exception codes and EX/MEM stage FSM encoding.
package cpu_pkg;

  localparam logic [3:0] AluAdd   = 4'h1;
  localparam logic [3:0] AluSub   = 4'h2;
  localparam logic [3:0] AluMul   = 4'h4;
  localparam logic [3:0] AluDiv   = 4'h8;
  localparam logic [3:0] AluAndi  = 4'hC;
  localparam logic [3:0] AluOri   = 4'hE;
  localparam logic [3:0] AluAddNf = 4'hF;

  typedef enum logic [1:0] {
    ExcNone = 2'b00,
    ExcOvf  = 2'b01,
    ExcDiv0 = 2'b10
  } exc_code_e;

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StExc   = 2'b01,
    StDrain = 2'b10
  } state_e;

  // Ops whose secondary result (high product / remainder) is architecturally written.
  function automatic logic is_r0_op(input logic [3:0] ctrl);
    return (ctrl == AluMul) || (ctrl == AluDiv);
  endfunction

  function automatic logic is_ovf_op(input logic [3:0] ctrl);
    return (ctrl == AluAdd) || (ctrl == AluSub) || (ctrl == AluAddNf);
  endfunction

endpackage

// File: rtl/exc_detect.sv
// Combinational fault classification for the execute-stage result.
module exc_detect
  import cpu_pkg::*;
(
  input  logic       in_valid,
  input  logic [3:0] alu_ctrl,
  input  logic       overflow_flag,
  input  logic       divisor_zero,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       r0_write
);

  logic div0;
  logic ovf;

  always_comb begin
    div0       = in_valid && (alu_ctrl == AluDiv) && divisor_zero;
    ovf        = in_valid && is_ovf_op(alu_ctrl) && overflow_flag;
    fault      = div0 || ovf;
    // Divide-by-zero takes priority when both conditions are present.
    fault_code = div0 ? ExcDiv0 : (ovf ? ExcOvf : ExcNone);
    r0_write   = in_valid && is_r0_op(alu_ctrl) && !fault;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall, flush and a RUN/EXC/DRAIN exception handshake.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RADDR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_r0,
  input  logic [3:0]       alu_ctrl,
  input  logic             overflow_flag,
  input  logic             divisor_zero,
  input  logic [1:0]       branch_result,
  input  logic [RADDR-1:0] rd_addr,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_stall,
  input  logic             flush,
  input  logic             exc_ack,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] q_r0,
  output logic [1:0]       q_branch,
  output logic [RADDR-1:0] q_rd,
  output logic             q_reg_write,
  output logic             q_r0_write,
  output logic             q_mem_read,
  output logic             q_mem_write,
  output logic             hold_up,
  output logic             exception,
  output logic [1:0]       exc_code
);

  logic       fault;
  logic [1:0] fault_code;
  logic       r0_write;

  state_e    state_q;
  exc_code_e exc_code_q;

  exc_detect u_exc_detect (
    .in_valid      (in_valid),
    .alu_ctrl      (alu_ctrl),
    .overflow_flag (overflow_flag),
    .divisor_zero  (divisor_zero),
    .fault         (fault),
    .fault_code    (fault_code),
    .r0_write      (r0_write)
  );

  assign hold_up  = mem_stall || (state_q != StRun);
  assign exc_code = exc_code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      exc_code_q  <= ExcNone;
      exception   <= 1'b0;
      q_valid     <= 1'b0;
      q_out       <= '0;
      q_r0        <= '0;
      q_branch    <= '0;
      q_rd        <= '0;
      q_reg_write <= 1'b0;
      q_r0_write  <= 1'b0;
      q_mem_read  <= 1'b0;
      q_mem_write <= 1'b0;
    end else begin
      // Squash leaves data fields intact; only validity and write enables are cleared.
      if (flush || (state_q == StDrain)) begin
        q_valid     <= 1'b0;
        q_reg_write <= 1'b0;
        q_r0_write  <= 1'b0;
        q_mem_read  <= 1'b0;
        q_mem_write <= 1'b0;
      end

      case (state_q)
        StRun: begin
          if (!flush && !mem_stall) begin
            q_out    <= alu_out;
            q_branch <= branch_result;
            q_rd     <= rd_addr;
            if (fault) begin
              q_valid     <= 1'b0;
              q_reg_write <= 1'b0;
              q_r0_write  <= 1'b0;
              q_mem_read  <= 1'b0;
              q_mem_write <= 1'b0;
              exception   <= 1'b1;
              exc_code_q  <= exc_code_e'(fault_code);
              state_q     <= StExc;
            end else begin
              q_valid     <= in_valid;
              q_reg_write <= in_valid && reg_write;
              q_r0_write  <= r0_write;
              q_mem_read  <= in_valid && mem_read;
              q_mem_write <= in_valid && mem_write;
              if (r0_write) begin
                q_r0 <= alu_r0;
              end
            end
          end
        end
        StExc: begin
          if (exc_ack) begin
            exception  <= 1'b0;
            exc_code_q <= ExcNone;
            state_q    <= StDrain;
          end
        end
        StDrain: begin
          state_q <= StRun;
        end
        default: begin
          exception  <= 1'b0;
          exc_code_q <= ExcNone;
          state_q    <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed table-driven bench for ex_mem_stage plus hand-written reset-in-exception sequence.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] alu_out;
  logic [15:0] alu_r0;
  logic [3:0]  alu_ctrl;
  logic        overflow_flag;
  logic        divisor_zero;
  logic [1:0]  branch_result;
  logic [3:0]  rd_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_stall;
  logic        flush;
  logic        exc_ack;
  logic        q_valid;
  logic [15:0] q_out;
  logic [15:0] q_r0;
  logic [1:0]  q_branch;
  logic [3:0]  q_rd;
  logic        q_reg_write;
  logic        q_r0_write;
  logic        q_mem_read;
  logic        q_mem_write;
  logic        hold_up;
  logic        exception;
  logic [1:0]  exc_code;

  ex_mem_stage #(
    .WIDTH (16),
    .RADDR (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .alu_out       (alu_out),
    .alu_r0        (alu_r0),
    .alu_ctrl      (alu_ctrl),
    .overflow_flag (overflow_flag),
    .divisor_zero  (divisor_zero),
    .branch_result (branch_result),
    .rd_addr       (rd_addr),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_stall     (mem_stall),
    .flush         (flush),
    .exc_ack       (exc_ack),
    .q_valid       (q_valid),
    .q_out         (q_out),
    .q_r0          (q_r0),
    .q_branch      (q_branch),
    .q_rd          (q_rd),
    .q_reg_write   (q_reg_write),
    .q_r0_write    (q_r0_write),
    .q_mem_read    (q_mem_read),
    .q_mem_write   (q_mem_write),
    .hold_up       (hold_up),
    .exception     (exception),
    .exc_code      (exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned iv, out, r0, ctrl, ovf, dz, br, rd, rw, mr, mw, stall, fl, ack;
    int unsigned e_v, e_out, e_r0, e_br, e_rd, e_rw, e_r0w, e_mr, e_mw, e_exc, e_code, e_hold;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid      = v.iv[0];
    alu_out       = v.out[15:0];
    alu_r0        = v.r0[15:0];
    alu_ctrl      = v.ctrl[3:0];
    overflow_flag = v.ovf[0];
    divisor_zero  = v.dz[0];
    branch_result = v.br[1:0];
    rd_addr       = v.rd[3:0];
    reg_write     = v.rw[0];
    mem_read      = v.mr[0];
    mem_write     = v.mw[0];
    mem_stall     = v.stall[0];
    flush         = v.fl[0];
    exc_ack       = v.ack[0];
  endtask

  task automatic compare(input int idx, input vec_t v);
    chk("q_valid",     idx, 32'(q_valid),     v.e_v);
    chk("q_out",       idx, 32'(q_out),       v.e_out);
    chk("q_r0",        idx, 32'(q_r0),        v.e_r0);
    chk("q_branch",    idx, 32'(q_branch),    v.e_br);
    chk("q_rd",        idx, 32'(q_rd),        v.e_rd);
    chk("q_reg_write", idx, 32'(q_reg_write), v.e_rw);
    chk("q_r0_write",  idx, 32'(q_r0_write),  v.e_r0w);
    chk("q_mem_read",  idx, 32'(q_mem_read),  v.e_mr);
    chk("q_mem_write", idx, 32'(q_mem_write), v.e_mw);
    chk("exception",   idx, 32'(exception),   v.e_exc);
    chk("exc_code",    idx, 32'(exc_code),    v.e_code);
    chk("hold_up",     idx, 32'(hold_up),     v.e_hold);
  endtask

  vec_t idle;

  initial begin
    // inputs: iv out r0 ctrl ovf dz br rd rw mr mw stall fl ack
    // expect: v out r0 br rd rw r0w mr mw exc code hold
    vecs[0]  = '{1, 'h0007, 'h0000, 'h1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,
                 1, 'h0007, 'h0000, 0, 5, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 'h2000, 'h0001, 'h4, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0,
                 1, 'h2000, 'h0001, 1, 6, 1, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 'h00F0, 'hBEEF, 'hC, 0, 0, 2, 7, 1, 0, 0, 0, 0, 0,
                 1, 'h00F0, 'h0001, 2, 7, 1, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 'h1234, 'h0000, 'hE, 0, 0, 3, 2, 0, 0, 1, 0, 0, 0,
                 1, 'h1234, 'h0001, 3, 2, 0, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{1, 'h5555, 'h7777, 'h3, 1, 1, 0, 3, 1, 1, 0, 0, 0, 0,
                 1, 'h5555, 'h0001, 0, 3, 1, 0, 1, 0, 0, 0, 0};
    vecs[5]  = '{0, 'h0AAA, 'h0000, 'h4, 0, 0, 1, 9, 1, 1, 1, 0, 0, 0,
                 0, 'h0AAA, 'h0001, 1, 9, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 'h0003, 'h0002, 'h8, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0,
                 1, 'h0003, 'h0002, 0, 4, 1, 1, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 'h7777, 'h3333, 'h1, 0, 0, 2, 1, 1, 0, 1, 1, 0, 0,
                 1, 'h0003, 'h0002, 0, 4, 1, 1, 0, 0, 0, 0, 1};
    vecs[8]  = '{1, 'h8888, 'h4444, 'h2, 1, 0, 2, 1, 1, 0, 0, 1, 0, 0,
                 1, 'h0003, 'h0002, 0, 4, 1, 1, 0, 0, 0, 0, 1};
    vecs[9]  = '{1, 'h9999, 'h5555, 'h8, 0, 1, 2, 1, 1, 0, 0, 1, 0, 0,
                 1, 'h0003, 'h0002, 0, 4, 1, 1, 0, 0, 0, 0, 1};
    vecs[10] = '{1, 'h9999, 'h5555, 'h4, 0, 0, 2, 1, 1, 0, 0, 1, 1, 0,
                 0, 'h0003, 'h0002, 0, 4, 0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{1, 'h8000, 'h0000, 'h2, 1, 0, 3, 8, 1, 0, 0, 0, 0, 0,
                 0, 'h8000, 'h0002, 3, 8, 0, 0, 0, 0, 1, 1, 1};
    vecs[12] = '{1, 'h1111, 'h0000, 'h1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,
                 0, 'h8000, 'h0002, 3, 8, 0, 0, 0, 0, 1, 1, 1};
    vecs[13] = '{1, 'h1111, 'h0000, 'h1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0,
                 0, 'h8000, 'h0002, 3, 8, 0, 0, 0, 0, 1, 1, 1};
    vecs[14] = '{0, 'h1111, 'h0000, 'h1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1,
                 0, 'h8000, 'h0002, 3, 8, 0, 0, 0, 0, 0, 0, 1};
    vecs[15] = '{1, 'h0042, 'h0000, 'h1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1,
                 0, 'h8000, 'h0002, 3, 8, 0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{1, 'h0042, 'h0000, 'h1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1,
                 1, 'h0042, 'h0002, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[17] = '{1, 'hFFFF, 'h0099, 'h8, 1, 1, 2, 2, 1, 0, 0, 0, 0, 0,
                 0, 'hFFFF, 'h0002, 2, 2, 0, 0, 0, 0, 1, 2, 1};
    vecs[18] = '{0, 'h0000, 'h0000, 'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                 0, 'hFFFF, 'h0002, 2, 2, 0, 0, 0, 0, 0, 0, 1};
    vecs[19] = '{0, 'h0000, 'h0000, 'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 'hFFFF, 'h0002, 2, 2, 0, 0, 0, 0, 0, 0, 0};
    vecs[20] = '{1, 'h6666, 'h0000, 'h1, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0,
                 0, 'hFFFF, 'h0002, 2, 2, 0, 0, 0, 0, 0, 0, 0};
    vecs[21] = '{1, 'h0123, 'h0000, 'hF, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0,
                 0, 'h0123, 'h0002, 1, 3, 0, 0, 0, 0, 1, 1, 1};

    idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    drive(idle);
    @(negedge clk);
    @(negedge clk);
    compare(-1, idle);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      compare(i, vecs[i]);
    end

    // Reset asserted between edges while in EXC: outputs clear without a clock.
    @(negedge clk);
    drive(idle);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_q_valid",   100, 32'(q_valid),   32'd0);
    chk("rst_q_out",     100, 32'(q_out),     32'd0);
    chk("rst_q_r0",      100, 32'(q_r0),      32'd0);
    chk("rst_q_rd",      100, 32'(q_rd),      32'd0);
    chk("rst_q_branch",  100, 32'(q_branch),  32'd0);
    chk("rst_exception", 100, 32'(exception), 32'd0);
    chk("rst_exc_code",  100, 32'(exc_code),  32'd0);
    chk("rst_hold_up",   100, 32'(hold_up),   32'd0);
    mem_stall = 1'b1;
    #1;
    chk("rst_hold_stall", 100, 32'(hold_up), 32'd1);
    mem_stall = 1'b0;

    @(negedge clk);
    rst           = 1'b0;
    in_valid      = 1'b1;
    alu_out       = 16'h0055;
    alu_ctrl      = 4'h1;
    rd_addr       = 4'd5;
    reg_write     = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_q_valid",   101, 32'(q_valid),     32'd1);
    chk("post_rst_q_out",     101, 32'(q_out),       32'h0055);
    chk("post_rst_q_rw",      101, 32'(q_reg_write), 32'd1);
    chk("post_rst_exception", 101, 32'(exception),   32'd0);
    chk("post_rst_hold_up",   101, 32'(hold_up),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
